regfile_mp: RTL and testbench

Parametrised multi-port register file: one read/write port (A) plus NR independent read ports (R), with per-entry valid tracking and single-cycle bulk invalidate. Used wherever a pipeline needs more than one simultaneous operand read from the same storage, such as register banks and tag/state arrays. Adds optional registered reads with write-first bypass, clock-enable stall and defined read data after reset, none of which the plain dual-port array provides.

---
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - Multi-port register file with per-entry valid and bulk invalidate
//
// One read/write port (A) plus NR read-only ports (R). Every read is gated by the
// entry's valid bit, so uninitialised array contents never reach an output.
//
// Ports:
//   clk_i, rst_ni  clock (rising edge) and asynchronous active-low reset
//   ena_i          global clock enable; low freezes all state
//   adr_i, dat_i   port A address and write data
//   wre_i, clr_i   port A write enable and invalidate-all
//   dat_o, vld_o   port A combinational read data and valid
//   radr_i         R-port addresses, port k at [k*AW +: AW]
//   rdat_o, rvld_o R-port read data (port k at [k*DW +: DW]) and valid (bit k)
module regfile_mp #(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int NR      = 2,
    parameter int REG_OUT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    input  logic [AW-1:0]    adr_i,
    input  logic [DW-1:0]    dat_i,
    input  logic             wre_i,
    input  logic             clr_i,
    output logic [DW-1:0]    dat_o,
    output logic             vld_o,
    input  logic [NR*AW-1:0] radr_i,
    output logic [NR*DW-1:0] rdat_o,
    output logic [NR-1:0]    rvld_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [NR*DW-1:0] rdat_q, rdat_d, rdat_comb;
    logic [NR-1:0]    rvld_q, rvld_d, rvld_comb;
    logic             wr_en;
    logic             clr_en;

    assign wr_en  = ena_i & wre_i;
    assign clr_en = ena_i & clr_i;

    // Clear first, then write, so a coincident write leaves its entry valid.
    always_comb begin
        vld_d = vld_q;
        if (clr_en) begin
            vld_d = '0;
        end
        if (wr_en) begin
            vld_d[adr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Array is not reset; stale contents are hidden by the valid gating.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en) begin
            mem_q[adr_i] <= dat_i;
        end
    end

    assign vld_o = vld_q[adr_i];
    assign dat_o = vld_q[adr_i] ? mem_q[adr_i] : '0;

    // Gated read of the current array contents (read-before-write).
    always_comb begin
        rdat_comb = '0;
        rvld_comb = '0;
        for (int k = 0; k < NR; k++) begin
            rvld_comb[k] = vld_q[radr_i[k*AW +: AW]];
            rdat_comb[k*DW +: DW] = vld_q[radr_i[k*AW +: AW]] ? mem_q[radr_i[k*AW +: AW]] : '0;
        end
    end

    // Registered R ports: a same-edge write wins over clear, clear over the array.
    always_comb begin
        rdat_d = rdat_q;
        rvld_d = rvld_q;
        if (ena_i) begin
            for (int k = 0; k < NR; k++) begin
                if (wre_i && (radr_i[k*AW +: AW] == adr_i)) begin
                    rdat_d[k*DW +: DW] = dat_i;
                    rvld_d[k]          = 1'b1;
                end else if (clr_i) begin
                    rdat_d[k*DW +: DW] = '0;
                    rvld_d[k]          = 1'b0;
                end else begin
                    rdat_d[k*DW +: DW] = rdat_comb[k*DW +: DW];
                    rvld_d[k]          = rvld_comb[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdat_q <= '0;
            rvld_q <= '0;
        end else begin
            rdat_q <= rdat_d;
            rvld_q <= rvld_d;
        end
    end

    assign rdat_o = (REG_OUT != 0) ? rdat_q : rdat_comb;
    assign rvld_o = (REG_OUT != 0) ? rvld_q : rvld_comb;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - Directed self-checking bench for regfile_mp
module tb_regfile_mp;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ena_i;
    logic [4:0]  adr_i;
    logic [31:0] dat_i;
    logic        wre_i;
    logic        clr_i;
    logic [9:0]  radr_i;

    logic [31:0] dat_o, c_dat_o;
    logic        vld_o, c_vld_o;
    logic [63:0] rdat_o, c_rdat_o;
    logic [1:0]  rvld_o, c_rvld_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    regfile_mp #(.AW(5), .DW(32), .NR(2), .REG_OUT(1)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ena_i(ena_i), .adr_i(adr_i), .dat_i(dat_i),
        .wre_i(wre_i), .clr_i(clr_i), .dat_o(dat_o), .vld_o(vld_o),
        .radr_i(radr_i), .rdat_o(rdat_o), .rvld_o(rvld_o)
    );

    regfile_mp #(.AW(5), .DW(32), .NR(2), .REG_OUT(0)) u_dut_comb (
        .clk_i(clk_i), .rst_ni(rst_ni), .ena_i(ena_i), .adr_i(adr_i), .dat_i(dat_i),
        .wre_i(wre_i), .clr_i(clr_i), .dat_o(c_dat_o), .vld_o(c_vld_o),
        .radr_i(radr_i), .rdat_o(c_rdat_o), .rvld_o(c_rvld_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] addrs [3];
        addrs[0] = 5'd0; addrs[1] = 5'd7; addrs[2] = 5'd31;
        rst_ni = 1'b0; ena_i = 1'b1; adr_i = '0; dat_i = '0;
        wre_i = 1'b0; clr_i = 1'b0; radr_i = '0;
        tick(); tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adr_i  = addrs[i];
            radr_i = {addrs[i], addrs[i]};
            tick();
            n_checks++;
            if (dat_o !== 32'h0 || vld_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_port_a adr=%0d: dat_o=%h vld_o=%b, want 0/0", addrs[i], dat_o, vld_o);
            end
            n_checks++;
            if (rdat_o !== 64'h0 || rvld_o !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_rport adr=%0d: rdat_o=%h rvld_o=%b, want 0/00", addrs[i], rdat_o, rvld_o);
            end
            n_checks++;
            if (c_rdat_o !== 64'h0 || c_rvld_o !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_rport_comb adr=%0d: rdat_o=%h rvld_o=%b, want 0/00", addrs[i], c_rdat_o, c_rvld_o);
            end
        end
    endtask

    task automatic test_write_read();
        adr_i = 5'd3; dat_i = 32'hDEADBEEF; wre_i = 1'b1; radr_i = {5'd3, 5'd3};
        tick();
        wre_i = 1'b0;
        #1;
        n_checks++;
        if (rdat_o !== {2{32'hDEADBEEF}} || rvld_o !== 2'b11) begin
            n_fail++;
            $display("FAIL write_read_rport: rdat_o=%h rvld_o=%b, want deadbeefdeadbeef/11", rdat_o, rvld_o);
        end
        n_checks++;
        if (dat_o !== 32'hDEADBEEF || vld_o !== 1'b1) begin
            n_fail++;
            $display("FAIL write_read_port_a: dat_o=%h vld_o=%b, want deadbeef/1", dat_o, vld_o);
        end
        n_checks++;
        if (c_rdat_o !== {2{32'hDEADBEEF}} || c_rvld_o !== 2'b11) begin
            n_fail++;
            $display("FAIL write_read_comb: rdat_o=%h rvld_o=%b, want deadbeefdeadbeef/11", c_rdat_o, c_rvld_o);
        end
    endtask

    task automatic test_bypass();
        adr_i = 5'd5; dat_i = 32'h1234; wre_i = 1'b1; radr_i = {5'd3, 5'd5};
        #1;
        n_checks++;
        if (dat_o !== 32'h0 || vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_port_a_prewrite: dat_o=%h vld_o=%b, want 0/0", dat_o, vld_o);
        end
        n_checks++;
        if (c_rdat_o[31:0] !== 32'h0 || c_rvld_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_comb_old: rdat0=%h rvld0=%b, want 0/0", c_rdat_o[31:0], c_rvld_o[0]);
        end
        tick();
        wre_i = 1'b0;
        #1;
        n_checks++;
        if (rdat_o !== {32'hDEADBEEF, 32'h1234} || rvld_o !== 2'b11) begin
            n_fail++;
            $display("FAIL bypass_reg: rdat_o=%h rvld_o=%b, want deadbeef00001234/11", rdat_o, rvld_o);
        end
        n_checks++;
        if (c_rdat_o[31:0] !== 32'h1234 || c_rvld_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_comb_new: rdat0=%h rvld0=%b, want 1234/1", c_rdat_o[31:0], c_rvld_o[0]);
        end
    endtask

    task automatic test_clear_write();
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            adr_i = 5'(i); dat_i = 32'h100 + 32'(i); wre_i = 1'b1;
            tick();
        end
        adr_i = 5'd2; dat_i = 32'hA5; wre_i = 1'b1; clr_i = 1'b1; radr_i = {5'd2, 5'd0};
        tick();
        wre_i = 1'b0; clr_i = 1'b0;
        #1;
        n_checks++;
        if (rdat_o !== {32'hA5, 32'h0} || rvld_o !== 2'b10) begin
            n_fail++;
            $display("FAIL clear_write_reg: rdat_o=%h rvld_o=%b, want 000000a500000000/10", rdat_o, rvld_o);
        end
        n_checks++;
        if (c_rdat_o !== {32'hA5, 32'h0} || c_rvld_o !== 2'b10) begin
            n_fail++;
            $display("FAIL clear_write_comb: rdat_o=%h rvld_o=%b, want 000000a500000000/10", c_rdat_o, c_rvld_o);
        end
        for (int i = 0; i < 4; i++) begin
            adr_i = 5'(i);
            #1;
            exp = (i == 2) ? 32'hA5 : 32'h0;
            n_checks++;
            if (dat_o !== exp || vld_o !== (i == 2)) begin
                n_fail++;
                $display("FAIL clear_write_port_a adr=%0d: dat_o=%h vld_o=%b, want %h/%b", i, dat_o, vld_o, exp, (i == 2));
            end
        end
    endtask

    task automatic test_stall();
        adr_i = 5'd2; radr_i = {5'd2, 5'd2}; wre_i = 1'b0; clr_i = 1'b0;
        tick();
        ena_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            radr_i = {5'(c + 8), 5'(c + 4)};
            adr_i  = 5'd7;
            dat_i  = 32'hBAD0 + 32'(c);
            wre_i  = 1'b1;
            clr_i  = (c != 1);
            tick();
            n_checks++;
            if (rdat_o !== {2{32'hA5}} || rvld_o !== 2'b11) begin
                n_fail++;
                $display("FAIL stall_hold cycle=%0d: rdat_o=%h rvld_o=%b, want 000000a5000000a5/11", c, rdat_o, rvld_o);
            end
        end
        ena_i = 1'b1; wre_i = 1'b0; clr_i = 1'b0;
        adr_i = 5'd7;
        #1;
        n_checks++;
        if (dat_o !== 32'h0 || vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_no_write: dat_o=%h vld_o=%b, want 0/0", dat_o, vld_o);
        end
        adr_i = 5'd2;
        #1;
        n_checks++;
        if (dat_o !== 32'hA5 || vld_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_no_clear: dat_o=%h vld_o=%b, want a5/1", dat_o, vld_o);
        end
    endtask

    task automatic test_async_reset();
        radr_i = {5'd10, 5'd10};
        adr_i = 5'd10; dat_i = 32'hC0DE0010; wre_i = 1'b1;
        tick();
        adr_i = 5'd11; dat_i = 32'hC0DE0011;
        tick();
        n_checks++;
        if (rdat_o !== {2{32'hC0DE0010}} || rvld_o !== 2'b11) begin
            n_fail++;
            $display("FAIL async_pre: rdat_o=%h rvld_o=%b, want c0de0010c0de0010/11", rdat_o, rvld_o);
        end
        adr_i = 5'd12; dat_i = 32'hC0DE0012;
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (rdat_o !== 64'h0 || rvld_o !== 2'b00 || c_rvld_o !== 2'b00) begin
            n_fail++;
            $display("FAIL async_immediate: rdat_o=%h rvld_o=%b comb_rvld=%b, want 0/00/00", rdat_o, rvld_o, c_rvld_o);
        end
        wre_i = 1'b0;
        adr_i = 5'd10;
        #1;
        n_checks++;
        if (dat_o !== 32'h0 || vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_port_a: dat_o=%h vld_o=%b, want 0/0", dat_o, vld_o);
        end
        tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 10; i < 13; i++) begin
            adr_i = 5'(i);
            #1;
            n_checks++;
            if (dat_o !== 32'h0 || vld_o !== 1'b0) begin
                n_fail++;
                $display("FAIL async_after adr=%0d: dat_o=%h vld_o=%b, want 0/0", i, dat_o, vld_o);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_clear_write();
        test_stall();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
